// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencer: centisecond counter with start/stop,
// lap freeze and clear, feeding the 7-seg display path.
module stopwatch_ctrl #(
    parameter int unsigned TICK_DIV = 500_000,
    parameter int unsigned MAX_CS   = 35_999_999
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btn_start_stop,
    input  logic        btn_lap_clear,
    output logic [31:0] run_time,
    output logic [31:0] lap_time,
    output logic        show_lap,
    output logic        running
);

    localparam int unsigned PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
    localparam logic [31:0]   CS_LAST  = 32'(MAX_CS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_LAP,
        S_STOP
    } state_e;

    state_e state_q, state_d;

    logic          ss;
    logic          lc;
    logic          counting;
    logic          tick;
    logic          clear;
    logic          capture;

    logic [PW-1:0] presc_q, presc_d;
    logic [31:0]   run_q, run_d;
    logic [31:0]   lap_q, lap_d;
    logic          show_q, show_d;
    logic          runn_q, runn_d;

    // start/stop always wins over a coincident lap/clear pulse
    assign ss = btn_start_stop;
    assign lc = btn_lap_clear & ~btn_start_stop;

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // FSM next-state decode
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (ss) state_d = S_RUN;
            S_RUN: begin
                if (ss)      state_d = S_STOP;
                else if (lc) state_d = S_LAP;
            end
            S_LAP: begin
                if (ss)      state_d = S_STOP;
                else if (lc) state_d = S_RUN;
            end
            S_STOP: begin
                if (ss)      state_d = S_RUN;
                else if (lc) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs, registered from the next state so they track state_q
    always_comb begin
        show_d = (state_d == S_LAP);
        runn_d = (state_d == S_RUN) || (state_d == S_LAP);
    end

    // prescaler and time counters; tick uses the current state
    always_comb begin
        counting = (state_q == S_RUN) || (state_q == S_LAP);
        tick     = counting && (presc_q == PRE_LAST);
        clear    = (state_q == S_STOP) && lc;
        capture  = (state_q == S_RUN) && lc;

        presc_d = presc_q;
        if (state_q == S_IDLE || clear) presc_d = '0;
        else if (tick)                  presc_d = '0;
        else if (counting)              presc_d = presc_q + 1'b1;

        run_d = run_q;
        if (clear)     run_d = '0;
        else if (tick) run_d = (run_q == CS_LAST) ? 32'd0 : run_q + 32'd1;

        lap_d = lap_q;
        if (clear)        lap_d = '0;
        else if (capture) lap_d = run_q;
    end

    // datapath and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q <= '0;
            run_q   <= '0;
            lap_q   <= '0;
            show_q  <= 1'b0;
            runn_q  <= 1'b0;
        end else begin
            presc_q <= presc_d;
            run_q   <= run_d;
            lap_q   <= lap_d;
            show_q  <= show_d;
            runn_q  <= runn_d;
        end
    end

    assign run_time = run_q;
    assign lap_time = lap_q;
    assign show_lap = show_q;
    assign running  = runn_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl: two instances share stimulus,
// one wrapping at 9 and one at 99, both with TICK_DIV=4.
module tb_stopwatch_ctrl;

    logic        clk;
    logic        rst;
    logic        ss;
    logic        lc;

    logic [31:0] a_run, a_lap;
    logic        a_show, a_runn;
    logic [31:0] b_run, b_lap;
    logic        b_show, b_runn;

    int checks = 0;
    int errors = 0;

    stopwatch_ctrl #(.TICK_DIV(4), .MAX_CS(9)) u_a (
        .clk            (clk),
        .rst            (rst),
        .btn_start_stop (ss),
        .btn_lap_clear  (lc),
        .run_time       (a_run),
        .lap_time       (a_lap),
        .show_lap       (a_show),
        .running        (a_runn)
    );

    stopwatch_ctrl #(.TICK_DIV(4), .MAX_CS(99)) u_b (
        .clk            (clk),
        .rst            (rst),
        .btn_start_stop (ss),
        .btn_lap_clear  (lc),
        .run_time       (b_run),
        .lap_time       (b_lap),
        .show_lap       (b_show),
        .running        (b_runn)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic pulse(input logic p_ss, input logic p_lc);
        ss = p_ss;
        lc = p_lc;
        cyc(1);
        ss = 1'b0;
        lc = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        ss  = 1'b0;
        lc  = 1'b0;
        cyc(2);
        rst = 1'b0;

        chk("rst_run", a_run, 0);
        chk("rst_lap", a_lap, 0);
        chk("rst_show", {31'd0, a_show}, 0);
        chk("rst_running", {31'd0, a_runn}, 0);

        pulse(1'b0, 1'b1);
        chk("idle_lc_run", a_run, 0);
        chk("idle_lc_lap", a_lap, 0);
        chk("idle_lc_show", {31'd0, a_show}, 0);
        chk("idle_lc_running", {31'd0, a_runn}, 0);

        pulse(1'b1, 1'b0);
        chk("start_running", {31'd0, a_runn}, 1);
        chk("start_run", a_run, 0);
        cyc(3);
        chk("pre_first_tick", a_run, 0);
        cyc(1);
        chk("first_tick", a_run, 1);
        cyc(16);
        chk("run_20cyc", a_run, 5);
        cyc(8);
        chk("run_7", b_run, 7);

        pulse(1'b0, 1'b1);
        chk("lap_capture", b_lap, 7);
        chk("lap_show", {31'd0, b_show}, 1);
        chk("lap_running", {31'd0, b_runn}, 1);
        cyc(3);
        chk("lap_keeps_count", b_run, 8);
        chk("lap_frozen", b_lap, 7);
        pulse(1'b0, 1'b1);
        chk("lap_release_show", {31'd0, b_show}, 0);
        chk("lap_release_lap", b_lap, 7);
        cyc(3);
        chk("at_max", a_run, 9);

        cyc(4);
        chk("wrap_run", a_run, 0);
        chk("wrap_running", {31'd0, a_runn}, 1);
        chk("nowrap_run", b_run, 10);

        cyc(1);
        pulse(1'b1, 1'b0);
        chk("stop_running", {31'd0, b_runn}, 0);
        chk("stop_show", {31'd0, b_show}, 0);
        chk("stop_lap_kept", b_lap, 7);
        cyc(50);
        chk("stopped_hold", b_run, 10);
        pulse(1'b1, 1'b0);
        chk("resume_running", {31'd0, b_runn}, 1);
        cyc(1);
        chk("resume_partial", b_run, 10);
        cyc(1);
        chk("resume_tick", b_run, 11);

        pulse(1'b1, 1'b0);
        pulse(1'b0, 1'b1);
        chk("clear_run", b_run, 0);
        chk("clear_lap", b_lap, 0);
        chk("clear_running", {31'd0, b_runn}, 0);
        cyc(5);
        chk("idle_hold", b_run, 0);

        pulse(1'b1, 1'b0);
        cyc(5);
        chk("t6_run", a_run, 1);
        pulse(1'b0, 1'b1);
        chk("t6_lap", a_lap, 1);
        pulse(1'b0, 1'b1);
        chk("t6_back_run", {31'd0, a_show}, 0);
        pulse(1'b1, 1'b1);
        chk("both_running", {31'd0, a_runn}, 0);
        chk("both_show", {31'd0, a_show}, 0);
        chk("both_lap", a_lap, 1);
        chk("both_run", a_run, 2);
        cyc(6);
        chk("both_stopped", a_run, 2);

        pulse(1'b1, 1'b0);
        cyc(2);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        chk("mid_rst_run", a_run, 0);
        chk("mid_rst_lap", a_lap, 0);
        chk("mid_rst_show", {31'd0, a_show}, 0);
        chk("mid_rst_running", {31'd0, a_runn}, 0);
        chk("mid_rst_b_run", b_run, 0);

        pulse(1'b1, 1'b0);
        cyc(7);
        chk("coin_pre", b_run, 1);
        pulse(1'b0, 1'b1);
        chk("coin_lap", b_lap, 1);
        chk("coin_run", b_run, 2);
        chk("coin_show", {31'd0, b_show}, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
